// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: state encoding, key map and
// helpers for decoding a sampled row pattern.
package keypad_pkg;

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;

    typedef enum logic [1:0] {
        KP_SCAN     = 2'd0,
        KP_DEBOUNCE = 2'd1,
        KP_HELD     = 2'd2
    } kp_state_e;

    // Row-major: index = {row, col}
    localparam logic [7:0] KEYMAP [16] = '{
        8'h31, 8'h32, 8'h33, 8'h41,
        8'h34, 8'h35, 8'h36, 8'h42,
        8'h37, 8'h38, 8'h39, 8'h43,
        8'h2A, 8'h30, 8'h23, 8'h44
    };

    function automatic logic [7:0] key_ascii(input logic [1:0] row, input logic [1:0] col);
        return KEYMAP[{row, col}];
    endfunction

    function automatic logic single_low(input logic [3:0] rows);
        return $onehot(~rows);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) idx = i[1:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/kp_row_sync.sv
// Two-flop synchronizer for the asynchronous keypad row inputs; idles high
// (no key) out of reset.
module kp_row_sync (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] row_sync
);

    logic [3:0] meta_q, meta_d;
    logic [3:0] sync_q, sync_d;

    always_comb begin
        meta_d = row_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 4'hF;
            sync_q <= 4'hF;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign row_sync = sync_q;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 active-low keypad scanner: column ring, per-slot row sampling, debounce
// FSM and a one-entry ASCII output buffer with valid/ready handshake.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       key_valid,
    output logic [7:0] key_code,
    input  logic       key_ready,
    output logic       key_pressed,
    output logic       overflow,
    input  logic       clr_ovf,
    output kp_state_e  dbg_state
);

    // Handshake: a key transfers on any cycle where key_valid & key_ready are both
    // high; key_valid/key_code never change while waiting for key_ready.

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = (DEBOUNCE_CNT > 0) ? $clog2(DEBOUNCE_CNT + 1) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_LIMIT  = CW'(DEBOUNCE_CNT);

    logic [3:0]    row_sync;
    logic [SW-1:0] slot_q, slot_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    state_q, state_d;
    logic [1:0]    row_q, row_d;
    logic [CW-1:0] dbcnt_q, dbcnt_d;
    logic [CW-1:0] relcnt_q, relcnt_d;
    logic          key_valid_q, key_valid_d;
    logic [7:0]    key_code_q, key_code_d;
    logic          key_pressed_q, key_pressed_d;
    logic          overflow_q, overflow_d;

    logic          sample;
    logic          accept;
    logic          release_key;
    logic          pop;
    logic          ovf_set;
    logic [CW-1:0] dbcnt_inc;
    logic [CW-1:0] relcnt_inc;

    kp_row_sync u_row_sync (
        .clk      (clk),
        .rst      (rst),
        .row_in   (row_in),
        .row_sync (row_sync)
    );

    always_comb begin
        slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
        sample = (slot_q == SLOT_LAST);
    end

    assign dbcnt_inc  = dbcnt_q + CW'(1);
    assign relcnt_inc = relcnt_q + CW'(1);

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        dbcnt_d     = dbcnt_q;
        relcnt_d    = relcnt_q;
        accept      = 1'b0;
        release_key = 1'b0;
        if (sample) begin
            case (state_q)
                ST_SCAN: begin
                    // Two or more rows low is a ghost pattern and is skipped like idle.
                    if (single_low(row_sync)) begin
                        row_d = low_index(row_sync);
                        if (DEBOUNCE_CNT == 1) begin
                            state_d  = ST_HELD;
                            accept   = 1'b1;
                            relcnt_d = '0;
                        end else begin
                            state_d = ST_DEBOUNCE;
                            dbcnt_d = CW'(1);
                        end
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (row_sync == ~(4'b0001 << row_q)) begin
                        if (dbcnt_inc == DB_LIMIT) begin
                            state_d  = ST_HELD;
                            accept   = 1'b1;
                            dbcnt_d  = '0;
                            relcnt_d = '0;
                        end else begin
                            dbcnt_d = dbcnt_inc;
                        end
                    end else begin
                        state_d = ST_SCAN;
                        dbcnt_d = '0;
                        col_d   = col_q + 2'd1;
                    end
                end
                ST_HELD: begin
                    // Only the latched row matters; other keys are ignored until release.
                    if (row_sync[row_q]) begin
                        if (relcnt_inc == DB_LIMIT) begin
                            state_d     = ST_SCAN;
                            relcnt_d    = '0;
                            col_d       = col_q + 2'd1;
                            release_key = 1'b1;
                        end else begin
                            relcnt_d = relcnt_inc;
                        end
                    end else begin
                        relcnt_d = '0;
                    end
                end
                default: begin
                    state_d = ST_SCAN;
                    dbcnt_d = '0;
                    relcnt_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        pop           = key_valid_q & key_ready;
        key_valid_d   = key_valid_q;
        key_code_d    = key_code_q;
        key_pressed_d = key_pressed_q;
        overflow_d    = overflow_q;
        ovf_set       = 1'b0;
        if (pop) key_valid_d = 1'b0;
        if (accept) begin
            key_pressed_d = 1'b1;
            // A pop on the same cycle frees the slot for the new key.
            if (!key_valid_q || pop) begin
                key_valid_d = 1'b1;
                key_code_d  = key_ascii(row_d, col_q);
            end else begin
                ovf_set = 1'b1;
            end
        end
        if (release_key) key_pressed_d = 1'b0;
        if (clr_ovf) overflow_d = 1'b0;
        if (ovf_set) overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q        <= '0;
            col_q         <= 2'd0;
            state_q       <= ST_SCAN;
            row_q         <= 2'd0;
            dbcnt_q       <= '0;
            relcnt_q      <= '0;
            key_valid_q   <= 1'b0;
            key_code_q    <= 8'h00;
            key_pressed_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            slot_q        <= slot_d;
            col_q         <= col_d;
            state_q       <= state_d;
            row_q         <= row_d;
            dbcnt_q       <= dbcnt_d;
            relcnt_q      <= relcnt_d;
            key_valid_q   <= key_valid_d;
            key_code_q    <= key_code_d;
            key_pressed_q <= key_pressed_d;
            overflow_q    <= overflow_d;
        end
    end

    assign col_out     = ~(4'b0001 << col_q);
    assign key_valid   = key_valid_q;
    assign key_code    = key_code_q;
    assign key_pressed = key_pressed_q;
    assign overflow    = overflow_q;
    assign dbg_state   = kp_state_e'(state_q);

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad matrix model drives the rows, and a
// sample-level reference model predicts every output cycle by cycle.
module tb_keypad_scan_ctrl;
    import keypad_pkg::*;

    localparam int DIV = 4;
    localparam int DB  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ready;
    logic       key_pressed;
    logic       overflow;
    logic       clr_ovf;
    kp_state_e  dbg_state;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(.SCAN_DIV(DIV), .DEBOUNCE_CNT(DB)) dut (
        .clk         (clk),
        .rst         (rst),
        .row_in      (row_in),
        .col_out     (col_out),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_ready   (key_ready),
        .key_pressed (key_pressed),
        .overflow    (overflow),
        .clr_ovf     (clr_ovf),
        .dbg_state   (dbg_state)
    );

    // Pressed keys, bit index = row*4 + col
    logic [15:0] keys;
    string       km = "123A456B789C*0#D";

    int          m_slot, m_col, m_mode, m_row, m_cnt;
    logic        m_valid, m_pressed, m_ovf;
    logic [7:0]  m_code;
    logic [3:0]  s1, s2;

    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic model_reset();
        m_slot = 0; m_col = 0; m_mode = 0; m_row = 0; m_cnt = 0;
        m_valid = 1'b0; m_pressed = 1'b0; m_ovf = 1'b0; m_code = 8'h00;
        s1 = 4'hF; s2 = 4'hF;
    endtask

    task automatic model_step();
        logic [3:0] rows, lows;
        int n;
        bit ev, rel, set_ovf, pop;
        if (rst) begin
            model_reset();
            return;
        end
        rows = s2;
        lows = ~rows;
        n = $countones(lows);
        ev = 0; rel = 0; set_ovf = 0;
        pop = m_valid && key_ready;
        if (pop) got_q.push_back(m_code);
        if (m_slot == DIV - 1) begin
            if (m_mode == 0) begin
                if (n == 1) begin
                    for (int r = 0; r < 4; r++) if (lows[r]) m_row = r;
                    m_mode = 1;
                    m_cnt = 1;
                end else begin
                    m_col = (m_col + 1) % 4;
                end
            end else if (m_mode == 1) begin
                if (n == 1 && lows[m_row]) begin
                    m_cnt++;
                    if (m_cnt == DB) begin
                        m_mode = 2; m_cnt = 0; ev = 1;
                    end
                end else begin
                    m_mode = 0; m_cnt = 0; m_col = (m_col + 1) % 4;
                end
            end else begin
                if (rows[m_row]) m_cnt++;
                else m_cnt = 0;
                if (m_cnt == DB) begin
                    m_mode = 0; m_cnt = 0; m_col = (m_col + 1) % 4; rel = 1;
                end
            end
        end
        if (pop) m_valid = 1'b0;
        if (ev) begin
            m_pressed = 1'b1;
            if (!m_valid) begin
                m_valid = 1'b1;
                m_code = km[m_row * 4 + m_col];
            end else begin
                set_ovf = 1;
            end
        end
        if (rel) m_pressed = 1'b0;
        if (clr_ovf) m_ovf = 1'b0;
        if (set_ovf) m_ovf = 1'b1;
        s2 = s1;
        s1 = row_in;
        m_slot = (m_slot + 1) % DIV;
    endtask

    task automatic check_outputs();
        logic [3:0] exp_col;
        exp_col = 4'hF;
        exp_col[m_col] = 1'b0;
        n_vec += 5;
        if (col_out !== exp_col) begin
            n_err++; $display("FAIL col_out t=%0t got %b want %b", $time, col_out, exp_col);
        end
        if (key_valid !== m_valid) begin
            n_err++; $display("FAIL key_valid t=%0t got %b want %b", $time, key_valid, m_valid);
        end
        if (key_code !== m_code) begin
            n_err++; $display("FAIL key_code t=%0t got %h want %h", $time, key_code, m_code);
        end
        if (key_pressed !== m_pressed) begin
            n_err++; $display("FAIL key_pressed t=%0t got %b want %b", $time, key_pressed, m_pressed);
        end
        if (overflow !== m_ovf) begin
            n_err++; $display("FAIL overflow t=%0t got %b want %b", $time, overflow, m_ovf);
        end
    endtask

    task automatic tick();
        for (int r = 0; r < 4; r++) row_in[r] = ~keys[r * 4 + m_col];
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_mode(input int target, input int budget, input string what);
        int k;
        k = 0;
        while (m_mode != target && k < budget) begin
            tick();
            k++;
        end
        n_vec++;
        if (m_mode != target) begin
            n_err++;
            $display("FAIL timeout_%s got mode %0d want %0d", what, m_mode, target);
        end
    endtask

    task automatic check_pops(input string name);
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL %s_count got %0d keys want %0d", name, got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_vec++;
                if (got_q[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL %s_code[%0d] got %h want %h", name, i, got_q[i], exp_q[i]);
                end
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_values(input string name);
        n_vec += 6;
        if (col_out !== 4'b1110) begin n_err++; $display("FAIL %s_col got %b want 1110", name, col_out); end
        if (key_valid !== 1'b0) begin n_err++; $display("FAIL %s_valid got %b want 0", name, key_valid); end
        if (key_code !== 8'h00) begin n_err++; $display("FAIL %s_code got %h want 00", name, key_code); end
        if (key_pressed !== 1'b0) begin n_err++; $display("FAIL %s_pressed got %b want 0", name, key_pressed); end
        if (overflow !== 1'b0) begin n_err++; $display("FAIL %s_ovf got %b want 0", name, overflow); end
        if (dbg_state !== KP_SCAN) begin n_err++; $display("FAIL %s_state got %0d want 0", name, dbg_state); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        run(3);
        check_reset_values("reset");
        rst = 1'b0;
    endtask

    task automatic test_idle();
        int seen;
        seen = 0;
        keys = '0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (key_valid) seen++;
        end
        n_vec++;
        if (seen != 0) begin n_err++; $display("FAIL idle_valid got %0d cycles want 0", seen); end
        exp_q.delete();
        check_pops("idle");
    endtask

    task automatic test_hold_5();
        keys = 16'h0020;
        wait_mode(2, 200, "hold5_press");
        run(40);
        n_vec++;
        if (key_pressed !== 1'b1) begin n_err++; $display("FAIL hold5_pressed got %b want 1", key_pressed); end
        keys = '0;
        wait_mode(0, 100, "hold5_release");
        run(2);
        n_vec++;
        if (key_pressed !== 1'b0) begin n_err++; $display("FAIL hold5_released got %b want 0", key_pressed); end
        exp_q.push_back(8'h35);
        check_pops("hold5");
    endtask

    task automatic test_bounce();
        keys = 16'h0020;
        wait_mode(1, 200, "bounce_first");
        keys = '0;
        run(DIV);
        keys = 16'h0020;
        wait_mode(2, 200, "bounce_settle");
        run(8);
        keys = '0;
        wait_mode(0, 100, "bounce_release");
        run(4);
        exp_q.push_back(8'h35);
        check_pops("bounce");
    endtask

    task automatic test_overflow();
        key_ready = 1'b0;
        keys = 16'h0001;
        wait_mode(2, 200, "ovf_key1");
        run(4);
        keys = '0;
        wait_mode(0, 100, "ovf_rel1");
        keys = 16'h4000;
        wait_mode(2, 200, "ovf_hash");
        run(4);
        keys = '0;
        wait_mode(0, 100, "ovf_rel2");
        n_vec += 3;
        if (key_valid !== 1'b1) begin n_err++; $display("FAIL ovf_valid got %b want 1", key_valid); end
        if (key_code !== 8'h31) begin n_err++; $display("FAIL ovf_code got %h want 31", key_code); end
        if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", overflow); end
        key_ready = 1'b1;
        tick();
        exp_q.push_back(8'h31);
        check_pops("ovf");
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        n_vec++;
        if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b want 0", overflow); end
    endtask

    task automatic test_ghost();
        int seen;
        seen = 0;
        keys = 16'h0011;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (key_valid) seen++;
        end
        keys = '0;
        run(8);
        n_vec++;
        if (seen != 0) begin n_err++; $display("FAIL ghost_valid got %0d cycles want 0", seen); end
        check_pops("ghost");
    endtask

    task automatic test_back_to_back();
        int k;
        key_ready = 1'b0;
        keys = 16'h0002;
        wait_mode(2, 200, "b2b_key2");
        keys = '0;
        wait_mode(0, 100, "b2b_rel2");
        keys = 16'h0004;
        k = 0;
        while (m_mode != 2 && k < 300) begin
            key_ready = (m_slot == DIV - 1 && m_mode == 1 && m_cnt == DB - 1) ? 1'b1 : 1'b0;
            tick();
            k++;
        end
        key_ready = 1'b0;
        n_vec += 3;
        if (key_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid got %b want 1", key_valid); end
        if (key_code !== 8'h33) begin n_err++; $display("FAIL b2b_code got %h want 33", key_code); end
        if (overflow !== 1'b0) begin n_err++; $display("FAIL b2b_ovf got %b want 0", overflow); end
        exp_q.push_back(8'h32);
        check_pops("b2b_first");
        keys = '0;
        wait_mode(0, 100, "b2b_rel3");
        key_ready = 1'b1;
        run(2);
        exp_q.push_back(8'h33);
        check_pops("b2b_second");
    endtask

    task automatic test_reset_held();
        key_ready = 1'b1;
        keys = 16'h8000;
        wait_mode(2, 200, "rst_d_first");
        run(6);
        rst = 1'b1;
        tick();
        check_reset_values("rst_held");
        rst = 1'b0;
        got_q.delete();
        wait_mode(2, 200, "rst_d_again");
        run(3);
        exp_q.push_back(8'h44);
        check_pops("rst_held");
        keys = '0;
        wait_mode(0, 100, "rst_d_release");
    endtask

    task automatic test_random();
        for (int ep = 0; ep < 25; ep++) begin
            int kind, hold;
            kind = $urandom_range(0, 2);
            keys = '0;
            keys[$urandom_range(0, 15)] = 1'b1;
            if (kind == 1) keys[$urandom_range(0, 15)] = 1'b1;
            if (kind == 2) begin
                for (int i = 0; i < 24; i++) begin
                    if ($urandom_range(0, 3) == 0) keys = keys ^ (16'h0001 << m_row * 4 + m_col);
                    key_ready = ($urandom_range(0, 9) < 7);
                    clr_ovf = ($urandom_range(0, 19) == 0);
                    tick();
                end
            end
            hold = $urandom_range(20, 120);
            for (int i = 0; i < hold; i++) begin
                key_ready = ($urandom_range(0, 9) < 7);
                clr_ovf = ($urandom_range(0, 19) == 0);
                tick();
            end
            keys = '0;
            hold = $urandom_range(10, 60);
            for (int i = 0; i < hold; i++) begin
                key_ready = ($urandom_range(0, 9) < 7);
                clr_ovf = ($urandom_range(0, 19) == 0);
                tick();
            end
        end
        key_ready = 1'b1;
        clr_ovf = 1'b0;
        run(40);
        got_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        key_ready = 1'b1;
        clr_ovf = 1'b0;
        keys = '0;
        row_in = 4'hF;
        model_reset();
        @(negedge clk);
        test_reset();
        test_idle();
        test_hold_5();
        test_bounce();
        test_overflow();
        test_ghost();
        test_back_to_back();
        test_reset_held();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
